snake_body_tracker: RTL
=======================

Name: snake_body_tracker

Overview:
- Upstream neighbour of the score display and score tracker path.
- Maintains the snake's segment coordinates on a square grid and advances the snake on each game step tick.
- Detects apple, wall and self collisions and emits the one-cycle goodColl / badColl pulses that the score tracker consumes.
- Provides a registered cell-occupancy query port for the display renderer.

Parameters:
- GRID_BITS, 4, coordinate width; grid is 2**GRID_BITS cells per side (16x16).
- MAX_LEN, 32, maximum number of segments held.
- INIT_LEN, 3, snake length after reset or restart (2 <= INIT_LEN <= MAX_LEN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- step  in  1  one-cycle move tick from the game timer.
- direction  in  4  one-hot edge-detected direction pulse: [3] up, [2] down, [1] left, [0] right.
- apple_x, apple_y  in  GRID_BITS  current apple cell.
- query_x, query_y  in  GRID_BITS  renderer occupancy query cell.
- goodColl  out  1  one-cycle pulse: apple eaten.
- badColl  out  1  one-cycle pulse: wall or self hit.
- head_x, head_y  out  GRID_BITS  current head cell.
- length  out  $clog2(MAX_LEN+1)  current segment count.
- game_over  out  1  high while in the DEAD state.
- query_hit  out  1  query cell is occupied by an active segment (1-cycle latency).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state = IDLE; dir = right.
  - seg[0] = (GRID/2, GRID/2); seg[i] = (GRID/2 - i, GRID/2) for i < INIT_LEN.
  - length = INIT_LEN.
  - goodColl = badColl = game_over = query_hit = 0.
- States:
  - IDLE: step is ignored. Any valid direction pulse latches that direction and moves to RUN.
  - RUN: the snake advances on each step.
  - DEAD: segments are frozen. Any valid direction pulse restores the reset body and length, latches the direction, and moves to RUN.
- Direction filter:
  - A pulse is valid only if exactly one bit is set and it is not the opposite of the latched dir.
  - Invalid pulses are dropped with no state change.
- Direction/step ordering: when a direction pulse and step arrive in the same cycle, the step uses the previously latched dir; the new dir applies from the next step.
- On step in RUN, next head nh = seg[0] + unit vector of dir.
- Wall hit: nh would leave [0, GRID-1] (carry or borrow out of GRID_BITS). Result: badColl, move to DEAD, no segment update.
- Self hit: nh equals seg[i] for any i in 0..length-2. seg[length-1] is also checked when nh equals the apple cell (growth case). Result: badColl, DEAD, no segment update. Entering the departing tail cell is legal.
- Apple: nh == (apple_x, apple_y) with no hit.
  - goodColl is pulsed.
  - Segments shift (seg[i] <= seg[i-1], seg[0] <= nh).
  - length increments, saturating at MAX_LEN. At MAX_LEN, goodColl still pulses but there is no growth and the tail drops.
- Plain move: shift segments, length unchanged.
- Priority: badColl over goodColl. The two are never asserted in the same cycle.
- Collision latency: goodColl / badColl assert in the cycle after the step is sampled and are exactly one cycle wide.
- Step outside RUN: ignored. badColl is emitted once on DEAD entry only.
- Head outputs: head_x / head_y / length reflect registered state and update in the same cycle as goodColl.
- Query port: query_hit is registered, equal to OR over i < length of (seg[i] == query). It is valid one cycle after the query is presented, in all states.
- Reset mid-operation: rst overrides all in-flight activity, including a pending step or direction pulse in that cycle.

Optional Feature:
- Macro: WRAP_WALLS_EN.
- Defined: edges wrap modulo GRID. Moving off any edge re-enters from the opposite edge, and only self hits raise badColl.
- Undefined: leaving the grid is a wall hit, as described in Behaviour.

Test Plan:
1. rst, then direction=0001, step x3 -> head (11,8), length 3, no collision pulses.
2. apple at (9,8), RUN right, one step -> goodColl high for exactly 1 cycle, following cycle length=4, head (9,8).
3. head at (15,y) moving right, step -> badColl 1-cycle, game_over=1; further steps produce no pulses; then direction=1000 -> head (8,8), length 3, RUN. With WRAP_WALLS_EN the same step instead gives head (0,y) and no badColl.
4. Length 5, path up, left, down into own body, step -> badColl; head unchanged. Separately, a move into the departing tail cell gives no badColl.
5. Right-moving snake, direction=0010 (reverse) and direction=0011 (multi-hot) -> both ignored; head keeps moving right. direction and step in the same cycle -> that step uses the old dir.
6. query (7,8) after reset -> query_hit=1 next cycle; query (0,0) -> 0. rst asserted in the same cycle as step -> reset values, no pulse.

Source files
------------

// File: rtl/snake_body_tracker.sv
// snake_body_tracker: snake segment store, step/collision engine and registered occupancy query.
// Build option: define WRAP_WALLS_EN to make grid edges wrap instead of acting as walls.
module snake_body_tracker #(
    parameter int GRID_BITS = 4,
    parameter int MAX_LEN   = 32,
    parameter int INIT_LEN  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step,
    input  logic [3:0]                   direction,
    input  logic [GRID_BITS-1:0]         apple_x,
    input  logic [GRID_BITS-1:0]         apple_y,
    input  logic [GRID_BITS-1:0]         query_x,
    input  logic [GRID_BITS-1:0]         query_y,
    output logic                         goodColl,
    output logic                         badColl,
    output logic [GRID_BITS-1:0]         head_x,
    output logic [GRID_BITS-1:0]         head_y,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic                         game_over,
    output logic                         query_hit
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int GRID  = 1 << GRID_BITS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DEAD = 2'd2;

    // Screen orientation: up decrements y, down increments y.
    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    localparam logic [GRID_BITS-1:0] ONE      = GRID_BITS'(1);
    localparam logic [LEN_W-1:0]     LEN_INIT = LEN_W'(INIT_LEN);
    localparam logic [LEN_W-1:0]     LEN_MAX  = LEN_W'(MAX_LEN);

    function automatic logic [GRID_BITS-1:0] init_x(input int idx);
        return (idx < INIT_LEN) ? GRID_BITS'(GRID / 2 - idx) : '0;
    endfunction

    function automatic logic [GRID_BITS-1:0] init_y(input int idx);
        return (idx < INIT_LEN) ? GRID_BITS'(GRID / 2) : '0;
    endfunction

    logic [1:0]           state_q, state_d;
    logic [3:0]           dir_q, dir_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 good_q, good_d;
    logic                 bad_q, bad_d;
    logic                 hit_q, hit_d;
    logic [GRID_BITS-1:0] seg_x_q [MAX_LEN];
    logic [GRID_BITS-1:0] seg_y_q [MAX_LEN];
    logic [GRID_BITS-1:0] seg_x_d [MAX_LEN];
    logic [GRID_BITS-1:0] seg_y_d [MAX_LEN];

    logic [GRID_BITS-1:0] nh_x, nh_y;
    logic [3:0]           dir_opp;
    logic                 dir_onehot, dir_valid;
    logic                 eat, wall_hit, self_hit;
    logic                 shift, restart;
    logic [MAX_LEN-1:0]   self_vec, query_vec;

    assign dir_opp    = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};
    assign dir_onehot = (direction != 4'd0) && ((direction & (direction - 4'd1)) == 4'd0);
    assign dir_valid  = dir_onehot && (direction != dir_opp);

    always_comb begin
        nh_x = seg_x_q[0];
        nh_y = seg_y_q[0];
        case (dir_q)
            DIR_UP:    nh_y = seg_y_q[0] - ONE;
            DIR_DOWN:  nh_y = seg_y_q[0] + ONE;
            DIR_LEFT:  nh_x = seg_x_q[0] - ONE;
            DIR_RIGHT: nh_x = seg_x_q[0] + ONE;
            default: begin
                nh_x = seg_x_q[0];
                nh_y = seg_y_q[0];
            end
        endcase
    end

`ifdef WRAP_WALLS_EN
    assign wall_hit = 1'b0;
`else
    // Leaving the grid is exactly the case where the head sits on the edge it is moving towards.
    assign wall_hit = ((dir_q == DIR_RIGHT) && (&seg_x_q[0])) ||
                      ((dir_q == DIR_LEFT)  && (~|seg_x_q[0])) ||
                      ((dir_q == DIR_DOWN)  && (&seg_y_q[0])) ||
                      ((dir_q == DIR_UP)    && (~|seg_y_q[0]));
`endif

    assign eat = (nh_x == apple_x) && (nh_y == apple_y);

    // The tail only counts as an obstacle when it will not move away, i.e. on a growth step.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
        localparam logic [LEN_W-1:0] IDX_P1 = LEN_W'(gi + 1);
        assign self_vec[gi]  = (seg_x_q[gi] == nh_x) && (seg_y_q[gi] == nh_y) &&
                               ((IDX_P1 < len_q) || ((IDX_P1 == len_q) && eat));
        assign query_vec[gi] = (seg_x_q[gi] == query_x) && (seg_y_q[gi] == query_y) &&
                               (IDX_P1 <= len_q);
    end

    assign self_hit = |self_vec;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        len_d   = len_q;
        good_d  = 1'b0;
        bad_d   = 1'b0;
        hit_d   = |query_vec;
        shift   = 1'b0;
        restart = 1'b0;
        case (state_q)
            IDLE: begin
                if (dir_valid) begin
                    dir_d   = direction;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dir_valid) begin
                    dir_d = direction;
                end
                if (step) begin
                    if (wall_hit || self_hit) begin
                        bad_d   = 1'b1;
                        state_d = DEAD;
                    end else begin
                        good_d = eat;
                        shift  = 1'b1;
                        if (eat && (len_q < LEN_MAX)) begin
                            len_d = len_q + LEN_W'(1);
                        end
                    end
                end
            end
            DEAD: begin
                if (dir_valid) begin
                    restart = 1'b1;
                    dir_d   = direction;
                    len_d   = LEN_INIT;
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i];
            seg_y_d[i] = seg_y_q[i];
        end
        if (restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_d[i] = init_x(i);
                seg_y_d[i] = init_y(i);
            end
        end else if (shift) begin
            seg_x_d[0] = nh_x;
            seg_y_d[0] = nh_y;
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_x_d[i] = seg_x_q[i-1];
                seg_y_d[i] = seg_y_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_RIGHT;
            len_q   <= LEN_INIT;
            good_q  <= 1'b0;
            bad_q   <= 1'b0;
            hit_q   <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= init_y(i);
            end
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            len_q   <= len_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            hit_q   <= hit_d;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= seg_x_d[i];
                seg_y_q[i] <= seg_y_d[i];
            end
        end
    end

    assign goodColl  = good_q;
    assign badColl   = bad_q;
    assign head_x    = seg_x_q[0];
    assign head_y    = seg_y_q[0];
    assign length    = len_q;
    assign game_over = (state_q == DEAD);
    assign query_hit = hit_q;

endmodule
